branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side branch predictor: a direct-mapped branch target buffer where each entry holds a valid bit, a tag, a target and a 2-bit saturating direction counter.
- Produces the taken/not-taken prediction and predicted next PC in IF (PredF, NPC_PredF). The pipeline carries these to EX as PredE/NPC_PredE.
- Is the other end of the hazard unit's prediction interface: it consumes the resolved outcome and Pred_Error from EX to train itself and keep misprediction statistics.

Parameters:
- SET_ADDR_LEN, 6, index width; the table has 2^SET_ADDR_LEN entries.
- TAG_LEN, 32-SET_ADDR_LEN-2, derived; must not be overridden.

Ports:
- clk  input  1  clock
- CpuRst  input  1  reset, synchronous, active-high
- PCF  input  32  fetch PC being looked up
- PredF  output  1  predicted taken for PCF
- NPC_PredF  output  32  predicted next PC for PCF
- IsBrE  input  1  EX-stage instruction is a conditional branch
- StallE  input  1  EX stage stalled; blocks all updates
- PCE  input  32  PC of the EX-stage branch
- BranchE  input  1  actual outcome: taken
- BrNPC  input  32  actual taken target
- Pred_Error  input  2  bit0: taken but mispredicted (direction or target); bit1: predicted taken but not taken
- BrCount  output  32  resolved-branch counter
- MissCount  output  32  mispredicted-branch counter

Behaviour:
- Address split: idx = PC[SET_ADDR_LEN+1:2], tag = PC[31:SET_ADDR_LEN+2]. PC[1:0] is ignored.
- Lookup is combinational from table state, with zero latency.
  - hit = valid[idxF] && tag[idxF]==tagF.
  - PredF = hit && ctr[idxF][1].
  - NPC_PredF = PredF ? target[idxF] : PCF+4, with 32-bit wrap.
- Updates happen only at the posedge of clk, when IsBrE && !StallE && !CpuRst:
  - Hit, taken: ctr increments and saturates at 2'b11; target <= BrNPC.
  - Hit, not taken: ctr decrements and saturates at 2'b00; target unchanged.
  - Miss, taken: allocate the entry, overwriting any alias: valid=1, tag=tagE, target=BrNPC, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change.
- Statistics, under the same gating:
  - BrCount increments by 1.
  - MissCount increments by 1 when |Pred_Error.
  - Both wrap modulo 2^32.
- Reset at the posedge with CpuRst=1:
  - All valid bits 0, all ctr 2'b01, BrCount=0, MissCount=0.
  - Targets and tags are don't-care.
  - Resulting outputs: PredF=0, NPC_PredF=PCF+4.
  - CpuRst overrides a simultaneous update.
- Lookup and update in the same cycle to the same index: the lookup returns pre-update contents, and the new contents are visible the following cycle. No write-to-read bypass.
- StallE=1 freezes the table and both counters, regardless of IsBrE.
- Pred_Error is used only for statistics. Training uses BranchE and BrNPC directly, so a target mismatch on a hit is corrected by writing the target.
- IsBrE=0 (including JAL/JALR) causes no update.

Decomposition:
- Shared package holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - the default SET_ADDR_LEN;
  - PC_INC=32'd4.
- One sub-module, bht_sat_counter: a combinational 2-bit saturating next-state function with inputs ctr and taken, and output ctr_next.

Test Plan:
1. Reset, then PCF=0x100 -> PredF=0, NPC_PredF=0x104, BrCount=0, MissCount=0.
2. IsBrE=1, PCE=0x100, BranchE=1, BrNPC=0x80, Pred_Error=01 for one cycle; next cycle PCF=0x100 -> PredF=1, NPC_PredF=0x80, BrCount=1, MissCount=1.
3. Continue from 2: one not-taken update at PCE=0x100 (ctr 10->01) -> PredF=0, NPC_PredF=0x104. Then one taken update -> PredF=1. Three further taken updates leave ctr=11, and two not-taken updates are then needed before PredF=0.
4. Alias: after 2, a taken update at PCE=0x200 (same idx 0, tag 2) with BrNPC=0x300 -> PCF=0x100 gives PredF=0, NPC_PredF=0x104; PCF=0x200 gives PredF=1, NPC_PredF=0x300.
5. StallE=1 with IsBrE=1, BranchE=1, Pred_Error=01 for 3 cycles -> table, BrCount and MissCount unchanged. Also, a same-cycle lookup of the PCE being updated returns the old value, and the new value appears on the next cycle.
6. CpuRst=1 asserted mid-run in the same cycle as a taken update -> next cycle all lookups give PredF=0, and both counters read 0. Also, preload BrCount at 32'hFFFFFFFF via updates/force, apply one update -> BrCount wraps to 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predictor_pkg : shared encodings and defaults for the BTB predictor
// Rev 1.0
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

  localparam int DEFAULT_SET_ADDR_LEN = 6;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_bht_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bht_sat_counter : next state of a 2-bit saturating direction counter
// Rev 1.0
// ---------------------------------------------------------------------------
module bht_sat_counter
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) ctr_next = ctr_t'(ctr - 2'd1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predictor : direct-mapped BTB with 2-bit counters and miss statistics
// Rev 1.0
// ---------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int SET_ADDR_LEN = DEFAULT_SET_ADDR_LEN,
  parameter int TAG_LEN      = 32 - SET_ADDR_LEN - 2
) (
  input  logic        clk,
  input  logic        CpuRst,
  input  logic [31:0] PCF,
  output logic        PredF,
  output logic [31:0] NPC_PredF,
  input  logic        IsBrE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BrNPC,
  input  logic [1:0]  Pred_Error,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int ENTRIES = 1 << SET_ADDR_LEN;

  logic                    valid_tab [ENTRIES];
  logic [TAG_LEN-1:0]      tag_tab   [ENTRIES];
  logic [31:0]             tgt_tab   [ENTRIES];
  ctr_t                    ctr_tab   [ENTRIES];

  logic [SET_ADDR_LEN-1:0] idx_f, idx_e;
  logic [TAG_LEN-1:0]      tag_f, tag_e;
  logic                    hit_f, hit_e, upd_en;
  ctr_t                    ctr_next_e;
  logic [31:0]             br_cnt, miss_cnt;
  logic                    unused_pc_lsbs;

  assign idx_f = PCF[SET_ADDR_LEN+1:2];
  assign tag_f = PCF[31:SET_ADDR_LEN+2];
  assign idx_e = PCE[SET_ADDR_LEN+1:2];
  assign tag_e = PCE[31:SET_ADDR_LEN+2];
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  // Lookup reads registered table state only: a same-cycle update is not bypassed.
  assign hit_f     = valid_tab[idx_f] && (tag_tab[idx_f] == tag_f);
  assign PredF     = hit_f && ctr_tab[idx_f][1];
  assign NPC_PredF = PredF ? tgt_tab[idx_f] : (PCF + PC_INC);

  assign hit_e  = valid_tab[idx_e] && (tag_tab[idx_e] == tag_e);
  assign upd_en = IsBrE && !StallE;

  bht_sat_counter u_sat_counter (
    .ctr      (ctr_tab[idx_e]),
    .taken    (BranchE),
    .ctr_next (ctr_next_e)
  );

  always_ff @(posedge clk) begin
    if (CpuRst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_tab[i] <= 1'b0;
        ctr_tab[i]   <= WNT;
      end
    end else if (upd_en) begin
      if (hit_e) begin
        ctr_tab[idx_e] <= ctr_next_e;
      end else if (BranchE) begin
        valid_tab[idx_e] <= 1'b1;
        ctr_tab[idx_e]   <= WT;
      end
    end
  end

  // On a hit the tag rewrite is a no-op, so taken hits and taken misses share one path.
  always_ff @(posedge clk) begin
    if (!CpuRst && upd_en && BranchE) begin
      tag_tab[idx_e] <= tag_e;
      tgt_tab[idx_e] <= BrNPC;
    end
  end

  always_ff @(posedge clk) begin
    if (CpuRst) begin
      br_cnt   <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (upd_en) begin
      br_cnt <= br_cnt + 32'd1;
      if (|Pred_Error) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign BrCount   = br_cnt;
  assign MissCount = miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_predictor : directed and randomized checks against a BTB model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        CpuRst;
  logic [31:0] PCF;
  logic        PredF;
  logic [31:0] NPC_PredF;
  logic        IsBrE;
  logic        StallE;
  logic [31:0] PCE;
  logic        BranchE;
  logic [31:0] BrNPC;
  logic [1:0]  Pred_Error;
  logic [31:0] BrCount;
  logic [31:0] MissCount;

  int tests = 0;
  int fails = 0;

  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic [31:0] m_br, m_miss;

  branch_predictor dut (
    .clk(clk), .CpuRst(CpuRst), .PCF(PCF), .PredF(PredF), .NPC_PredF(NPC_PredF),
    .IsBrE(IsBrE), .StallE(StallE), .PCE(PCE), .BranchE(BranchE), .BrNPC(BrNPC),
    .Pred_Error(Pred_Error), .BrCount(BrCount), .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd64);
  endfunction

  function automatic logic [32:0] m_look(input logic [31:0] pc);
    int i = ix(pc);
    if (m_valid[i] && m_tag[i] == (pc >> 8) && m_ctr[i] >= 2) return {1'b1, m_tgt[i]};
    return {1'b0, pc + 32'd4};
  endfunction

  // Advance the model with the inputs presented this cycle, then clock the DUT.
  task automatic tick();
    if (CpuRst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_br = 0;
      m_miss = 0;
    end else if (IsBrE && !StallE) begin
      int i = ix(PCE);
      if (m_valid[i] && m_tag[i] == (PCE >> 8)) begin
        if (BranchE) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = BrNPC;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (BranchE) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = PCE >> 8;
        m_tgt[i]   = BrNPC;
        m_ctr[i]   = 2;
      end
      m_br = m_br + 1;
      if (Pred_Error != 2'b00) m_miss = m_miss + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic isbr, input logic stall, input logic [31:0] pce,
                         input logic taken, input logic [31:0] npc, input logic [1:0] perr);
    IsBrE = isbr; StallE = stall; PCE = pce; BranchE = taken; BrNPC = npc; Pred_Error = perr;
  endtask

  task automatic idle();
    set_upd(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 2'b00);
  endtask

  task automatic test_reset();
    CpuRst = 1'b1;
    idle();
    PCF = 32'h0;
    tick();
    tick();
    CpuRst = 1'b0;
    PCF = 32'h100;
    #1;
    tests++;
    if ({PredF, NPC_PredF} !== {1'b0, 32'h104}) begin
      fails++; $display("FAIL reset_lookup got=%h exp=%h", {PredF, NPC_PredF}, {1'b0, 32'h104});
    end
    tests++;
    if ({BrCount, MissCount} !== 64'd0) begin
      fails++; $display("FAIL reset_counters got br=%h miss=%h exp 0/0", BrCount, MissCount);
    end
  endtask

  task automatic test_allocate();
    set_upd(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 2'b01);
    tick();
    idle();
    PCF = 32'h100;
    #1;
    tests++;
    if ({PredF, NPC_PredF} !== {1'b1, 32'h80}) begin
      fails++; $display("FAIL alloc_lookup got=%h exp=%h", {PredF, NPC_PredF}, {1'b1, 32'h80});
    end
    tests++;
    if (BrCount !== 32'd1 || MissCount !== 32'd1) begin
      fails++; $display("FAIL alloc_counters got br=%0d miss=%0d exp 1/1", BrCount, MissCount);
    end
  endtask

  task automatic test_hysteresis();
    bit taken_seq [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit pred_seq  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      set_upd(1'b1, 1'b0, 32'h100, taken_seq[k], 32'h80, 2'b00);
      tick();
      idle();
      PCF = 32'h100;
      #1;
      tests++;
      if ({PredF, NPC_PredF} !== {pred_seq[k], pred_seq[k] ? 32'h80 : 32'h104}) begin
        fails++; $display("FAIL hysteresis step=%0d got pred=%b npc=%h exp pred=%b",
                          k, PredF, NPC_PredF, pred_seq[k]);
      end
    end
  endtask

  task automatic test_alias();
    set_upd(1'b1, 1'b0, 32'h200, 1'b1, 32'h300, 2'b01);
    tick();
    idle();
    PCF = 32'h100;
    #1;
    tests++;
    if ({PredF, NPC_PredF} !== {1'b0, 32'h104}) begin
      fails++; $display("FAIL alias_old got=%h exp=%h", {PredF, NPC_PredF}, {1'b0, 32'h104});
    end
    PCF = 32'h200;
    #1;
    tests++;
    if ({PredF, NPC_PredF} !== {1'b1, 32'h300}) begin
      fails++; $display("FAIL alias_new got=%h exp=%h", {PredF, NPC_PredF}, {1'b1, 32'h300});
    end
  endtask

  task automatic test_stall_and_same_cycle();
    logic [31:0] br0 = BrCount;
    logic [31:0] miss0 = MissCount;
    for (int k = 0; k < 3; k++) begin
      set_upd(1'b1, 1'b1, (k == 1) ? 32'h100 : 32'h200, 1'b1, 32'h444, 2'b01);
      tick();
      PCF = 32'h200;
      #1;
      tests++;
      if ({PredF, NPC_PredF, BrCount, MissCount} !== {1'b1, 32'h300, br0, miss0}) begin
        fails++; $display("FAIL stall_freeze cyc=%0d got pred=%b npc=%h br=%0d miss=%0d",
                          k, PredF, NPC_PredF, BrCount, MissCount);
      end
    end
    set_upd(1'b1, 1'b0, 32'h100, 1'b1, 32'h500, 2'b01);
    PCF = 32'h100;
    #1;
    tests++;
    if ({PredF, NPC_PredF} !== {1'b0, 32'h104}) begin
      fails++; $display("FAIL same_cycle_old got=%h exp=%h", {PredF, NPC_PredF}, {1'b0, 32'h104});
    end
    tick();
    idle();
    #1;
    tests++;
    if ({PredF, NPC_PredF} !== {1'b1, 32'h500}) begin
      fails++; $display("FAIL same_cycle_new got=%h exp=%h", {PredF, NPC_PredF}, {1'b1, 32'h500});
    end
  endtask

  task automatic test_reset_override();
    CpuRst = 1'b1;
    set_upd(1'b1, 1'b0, 32'h100, 1'b1, 32'h600, 2'b01);
    tick();
    CpuRst = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      PCF = 32'h100 * (k + 1);
      #1;
      tests++;
      if ({PredF, NPC_PredF} !== {1'b0, PCF + 32'd4}) begin
        fails++; $display("FAIL rst_override pc=%h got=%h exp=%h", PCF, {PredF, NPC_PredF},
                          {1'b0, PCF + 32'd4});
      end
    end
    tests++;
    if ({BrCount, MissCount} !== 64'd0) begin
      fails++; $display("FAIL rst_override_cnt got br=%h miss=%h exp 0/0", BrCount, MissCount);
    end
  endtask

  task automatic test_wrap();
    force dut.br_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt;
    m_br = 32'hFFFF_FFFF;
    set_upd(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 2'b00);
    tick();
    idle();
    tests++;
    if (BrCount !== 32'd0) begin
      fails++; $display("FAIL br_wrap got=%h exp=00000000", BrCount);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] t = ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(1, 3));
    return (t << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      CpuRst = ($urandom_range(0, 99) == 0);
      set_upd($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rand_pc(),
              $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 32'h80 : 32'($urandom),
              2'($urandom_range(0, 3)));
      PCF = ($urandom_range(0, 1) == 1) ? PCE : rand_pc();
      #1;
      tests++;
      if ({PredF, NPC_PredF} !== m_look(PCF)) begin
        fails++; $display("FAIL rand_lookup n=%0d pc=%h got=%h exp=%h", n, PCF,
                          {PredF, NPC_PredF}, m_look(PCF));
      end
      tick();
      tests++;
      if (BrCount !== m_br || MissCount !== m_miss) begin
        fails++; $display("FAIL rand_counters n=%0d got br=%h miss=%h exp br=%h miss=%h",
                          n, BrCount, MissCount, m_br, m_miss);
      end
    end
    CpuRst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_stall_and_same_cycle();
    test_reset_override();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
